// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, reset PC,
// fill instruction and the {pc, inst, err} buffer entry layout.
package ysyx_22050039_ifu_pkg;

  localparam int          IFU_XLEN     = 64;
  localparam int          IFU_INST_LEN = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALT
  } ifu_state_t;

  typedef struct packed {
    logic [IFU_XLEN-1:0]     pc;
    logic [IFU_INST_LEN-1:0] inst;
    logic                    err;
  } ifu_entry_t;

endpackage

// File: rtl/ysyx_22050039_fetch_fifo.sv
// Circular fetch buffer.
//   i_push/i_din : write one entry (ignored when full)
//   i_pop        : retire head (ignored when empty)
//   i_flush      : drop everything; a push in the same cycle lands as the
//                  sole surviving entry
//   o_dout       : head entry, zero when empty
//   o_count/o_full/o_empty : occupancy
module ysyx_22050039_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 97
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop, w_we;
  logic [AW-1:0] w_widx;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_count = r_cnt;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;
  // After a flush the buffer restarts at slot 0.
  assign w_we   = i_flush ? i_push : w_push;
  assign w_widx = i_flush ? '0 : r_wr;

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_widx] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= i_push ? AW'(1) : '0;
      r_cnt <= i_push ? (AW+1)'(1) : '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch outstanding on the
// imem valid/ready port and buffers {pc, inst, err} for decode.
//   i_clk, i_rst (async, active low)
//   o_imem_req_valid/i_imem_req_ready/o_imem_addr : fetch request
//   i_imem_rsp_valid/i_imem_rsp_inst/i_imem_rsp_err : fetch response
//   i_redirect_valid/i_redirect_pc : taken branch/jump from execute
//   o_inst_valid/i_inst_ready/o_inst/o_inst_pc/o_inst_err : to decode
//   o_halted : fetch stopped after a fault, cleared by redirect
module ysyx_22050039_ifu
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter int              INST_LEN = IFU_INST_LEN,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic                o_imem_req_valid,
  input  logic                i_imem_req_ready,
  output logic [XLEN-1:0]     o_imem_addr,
  input  logic                i_imem_rsp_valid,
  input  logic [INST_LEN-1:0] i_imem_rsp_inst,
  input  logic                i_imem_rsp_err,
  input  logic                i_redirect_valid,
  input  logic [XLEN-1:0]     i_redirect_pc,
  output logic                o_inst_valid,
  input  logic                i_inst_ready,
  output logic [INST_LEN-1:0] o_inst,
  output logic [XLEN-1:0]     o_inst_pc,
  output logic                o_inst_err,
  output logic                o_halted
);

  localparam int EW = XLEN + INST_LEN + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_t    r_state, w_nxt_state;
  logic [XLEN-1:0] r_pc, w_nxt_pc;
  logic          r_pend;       // a response is still owed by memory
  logic          w_hs, w_pend_nxt, w_mis;
  logic          w_push, w_flush, w_full, w_empty;
  logic [EW-1:0] w_din, w_dout;
  logic [CW-1:0] w_count;

  assign o_imem_req_valid = (r_state == S_REQ) && !w_full;
  assign o_imem_addr      = r_pc;
  assign o_inst_valid     = !w_empty;
  assign o_halted         = (r_state == S_HALT);
  assign {o_inst_pc, o_inst, o_inst_err} = w_dout;

  assign w_hs       = o_imem_req_valid & i_imem_req_ready;
  assign w_pend_nxt = (r_pend & ~i_imem_rsp_valid) | w_hs;
  assign w_mis      = i_redirect_valid & (|i_redirect_pc[1:0]);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    w_push      = 1'b0;
    w_flush     = i_redirect_valid;
    w_din       = {r_pc, i_imem_rsp_inst, i_imem_rsp_err};
    if (i_redirect_valid) begin
      w_nxt_pc = i_redirect_pc;
      if (w_mis) begin
        // The flush empties the buffer, so the fault entry always fits now.
        w_push      = 1'b1;
        w_din       = {i_redirect_pc, {INST_LEN{1'b0}}, 1'b1};
        w_nxt_state = S_HALT;
      end else begin
        // Any response still owed belongs to the old path and must be eaten.
        w_nxt_state = w_pend_nxt ? S_DROP : S_REQ;
      end
    end else begin
      case (r_state)
        S_IDLE: w_nxt_state = S_REQ;
        S_REQ:  if (w_hs) w_nxt_state = S_WAIT;
        S_WAIT: if (i_imem_rsp_valid) begin
          w_push      = 1'b1;
          w_nxt_pc    = r_pc + XLEN'(4);
          w_nxt_state = i_imem_rsp_err ? S_HALT : S_REQ;
        end
        S_DROP: if (i_imem_rsp_valid) w_nxt_state = S_REQ;
        S_HALT: ;
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pc    <= w_nxt_pc;
      r_pend  <= w_pend_nxt;
    end
  end

  ysyx_22050039_fetch_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst),
    .i_push (w_push),
    .i_din  (w_din),
    .i_pop  (o_inst_valid & i_inst_ready),
    .i_flush(w_flush),
    .o_dout (w_dout),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
module tb_ysyx_22050039_ifu;
  import ysyx_22050039_ifu_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, rsp_err;
  logic [63:0] addr, redir_pc, inst_pc;
  logic [31:0] rsp_inst, inst;
  logic        redir_valid, inst_valid, inst_ready, inst_err, halted;

  int n_cmp = 0, n_fail = 0;

  // memory model state
  int          lat = 1, n_req = 0, m_cnt = 0;
  logic        m_pend = 0, err_en = 0;
  logic [63:0] m_addr = '0, err_addr = '0;

  ifu_entry_t sb[$];
  logic       sb_en = 0;

  ysyx_22050039_ifu dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_addr(addr),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_inst(rsp_inst), .i_imem_rsp_err(rsp_err),
    .i_redirect_valid(redir_valid), .i_redirect_pc(redir_pc),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready), .o_inst(inst),
    .o_inst_pc(inst_pc), .o_inst_err(inst_err), .o_halted(halted)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return {a[11:2], 15'b0, 7'h13};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Memory: one response per accepted request, lat cycles after acceptance.
  initial begin
    rsp_valid = 0; rsp_inst = '0; rsp_err = 0;
    forever begin
      @(negedge clk);
      rsp_valid = 0; rsp_err = 0;
      if (!rst) begin
        m_pend = 0;
      end else begin
        if (m_pend) begin
          if (m_cnt == 0) begin
            rsp_valid = 1;
            rsp_inst  = inst_of(m_addr);
            rsp_err   = err_en && (m_addr == err_addr);
            m_pend    = 0;
          end else m_cnt--;
        end
        if (req_valid && req_ready) begin
          m_pend = 1; m_addr = addr; m_cnt = lat - 1; n_req++;
        end
      end
    end
  end

  // Scoreboard checker: compares every entry decode consumes.
  initial begin
    ifu_entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst && sb_en && inst_valid && inst_ready) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_extra: got pc %h expected no entry", inst_pc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_pc", inst_pc, e.pc);
          chk("sb_inst", 64'(inst), 64'(e.inst));
          chk("sb_err", 64'(inst_err), 64'(e.err));
        end
      end
    end
  end

  task automatic exp_push(logic [63:0] pc, logic err);
    ifu_entry_t e;
    e.pc = pc; e.inst = err && pc[1:0] != 0 ? 32'h0 : inst_of(pc); e.err = err;
    sb.push_back(e);
  endtask

  task automatic drain(int budget);
    inst_ready = 1;
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    inst_ready = 0;
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic redirect(logic [63:0] pc);
    redir_valid = 1; redir_pc = pc;
    step();
    redir_valid = 0;
  endtask

  task automatic wait_mem_req(string tag, logic [63:0] a);
    for (int i = 0; i < 20; i++) begin
      if (m_pend && m_addr == a) break;
      step();
    end
    chk(tag, 64'(m_pend && m_addr == a), 64'd1);
  endtask

  task automatic wait_req_valid(string tag);
    for (int i = 0; i < 20; i++) begin
      if (req_valid) break;
      step();
    end
    chk(tag, 64'(req_valid), 64'd1);
  endtask

  int snap;

  initial begin
    rst = 0; req_ready = 1; redir_valid = 0; redir_pc = '0; inst_ready = 0;
    step(); step();
    chk("rst_req_valid", 64'(req_valid), 0);
    chk("rst_inst_valid", 64'(inst_valid), 0);
    chk("rst_inst", 64'(inst), 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_err", 64'(inst_err), 0);
    chk("rst_halted", 64'(halted), 0);

    // zero-wait streaming latency
    inst_ready = 1;
    rst = 1;
    wait_req_valid("t1_req");
    chk("t1_addr0", addr, 64'h8000_0000);
    step();
    chk("t1_c1_valid", 64'(inst_valid), 0);
    step();
    chk("t1_c2_valid", 64'(inst_valid), 1);
    chk("t1_c2_pc", inst_pc, 64'h8000_0000);
    chk("t1_c2_inst", 64'(inst), 64'h13);
    chk("t1_c2_addr", addr, 64'h8000_0004);
    step(); step();
    chk("t1_c4_valid", 64'(inst_valid), 1);
    chk("t1_c4_pc", inst_pc, 64'h8000_0004);
    step(); step();
    chk("t1_c6_valid", 64'(inst_valid), 1);
    chk("t1_c6_pc", inst_pc, 64'h8000_0008);

    // decode stall: buffer fills to 2, requests stop
    inst_ready = 0;
    snap = n_req;
    for (int i = 0; i < 10; i++) step();
    chk("t2_req_valid", 64'(req_valid), 0);
    chk("t2_inst_valid", 64'(inst_valid), 1);
    chk("t2_head_pc", inst_pc, 64'h8000_0008);
    chk("t2_no_req", 64'(n_req), 64'(snap));
    exp_push(64'h8000_0008, 0); exp_push(64'h8000_000c, 0); exp_push(64'h8000_0010, 0);
    sb_en = 1;
    drain(30);

    // redirect while waiting for a slow response
    for (int i = 0; i < 6; i++) step();
    chk("t3_prefull", 64'(inst_valid), 1);
    lat = 3;
    redirect(64'h8000_0040);
    chk("t3_flush", 64'(inst_valid), 0);
    wait_mem_req("t3_req40", 64'h8000_0040);
    step();
    redirect(64'h8000_0100);
    chk("t3_drop_noreq", 64'(req_valid), 0);
    chk("t3_drop_empty", 64'(inst_valid), 0);
    lat = 1;
    wait_req_valid("t3_req");
    chk("t3_addr", addr, 64'h8000_0100);
    exp_push(64'h8000_0100, 0); exp_push(64'h8000_0104, 0);
    drain(30);

    // redirect coinciding with a response
    for (int i = 0; i < 6; i++) step();
    redirect(64'h8000_0200);
    wait_mem_req("t4_req200", 64'h8000_0200);
    step();
    chk("t4_rsp_now", 64'(rsp_valid), 1);
    redirect(64'h8000_0300);
    chk("t4_no_push", 64'(inst_valid), 0);
    chk("t4_req_valid", 64'(req_valid), 1);
    chk("t4_addr", addr, 64'h8000_0300);
    exp_push(64'h8000_0300, 0); exp_push(64'h8000_0304, 0);
    drain(30);

    // access fault halts fetch; redirect resumes
    for (int i = 0; i < 4; i++) step();
    err_en = 1; err_addr = 64'h8000_0008;
    redirect(64'h8000_0000);
    exp_push(64'h8000_0000, 0); exp_push(64'h8000_0004, 0); exp_push(64'h8000_0008, 1);
    drain(40);
    snap = n_req;
    for (int i = 0; i < 5; i++) step();
    chk("t5_halted", 64'(halted), 1);
    chk("t5_req_valid", 64'(req_valid), 0);
    chk("t5_no_req", 64'(n_req), 64'(snap));
    chk("t5_empty", 64'(inst_valid), 0);
    err_en = 0;
    redirect(64'h8000_0000);
    chk("t5_unhalt", 64'(halted), 0);
    exp_push(64'h8000_0000, 0); exp_push(64'h8000_0004, 0);
    drain(30);

    // misaligned redirect target
    for (int i = 0; i < 4; i++) step();
    snap = n_req;
    exp_push(64'h8000_0102, 1);
    redirect(64'h8000_0102);
    chk("t6_valid", 64'(inst_valid), 1);
    chk("t6_pc", inst_pc, 64'h8000_0102);
    chk("t6_err", 64'(inst_err), 1);
    chk("t6_inst", 64'(inst), 0);
    chk("t6_halted", 64'(halted), 1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_no_req", 64'(n_req), 64'(snap));
    chk("t6_req_valid", 64'(req_valid), 0);
    drain(10);
    step(); step();
    chk("t6_single", 64'(inst_valid), 0);

    // reset in the middle of fetching
    redirect(64'h8000_0400);
    for (int i = 0; i < 3; i++) step();
    rst = 0;
    #1;
    chk("t7_req_valid", 64'(req_valid), 0);
    chk("t7_inst_valid", 64'(inst_valid), 0);
    chk("t7_inst_pc", inst_pc, 0);
    chk("t7_halted", 64'(halted), 0);
    step();
    rst = 1;
    wait_req_valid("t7_req");
    chk("t7_addr", addr, 64'h8000_0000);
    exp_push(64'h8000_0000, 0);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
